// File: rtl/clock_frac_gen.sv
// ---------------------------------------------------------------------------
// clock_frac_gen
//   Multi-channel fractional clock-enable generator built on phase
//   accumulators (DDS). Each channel adds its programmable increment to an
//   ACC_BITS-wide accumulator every cycle it is enabled. The carry out of
//   that add becomes a one-cycle enable pulse. The accumulator MSB becomes a
//   ~50% duty square clock. Output rate = f_clk_src * inc / 2^ACC_BITS.
//
//   Optional feature macro: CLOCK_FRAC_SYNC_EN
//     When defined, the 'sync' port is present. A sync strobe phase-aligns
//     every enabled channel by loading acc <= inc.
//
// Parameters
//   NUM_CH       number of channels (1..8)
//   ACC_BITS     accumulator / increment width (8..32)
//   INC_DEFAULT  reset increment for all channels (low ACC_BITS bits used)
//   SEL_W        width of inc_sel, defaults to max(1, $clog2(NUM_CH))
//
// Ports
//   clk_src   in   source clock; all logic on posedge
//   reset     in   synchronous, active-high
//   ch_en     in   per-channel run enable; 0 clears phase and outputs
//   inc_we    in   increment write strobe
//   inc_sel   in   channel addressed by inc_we; out-of-range is ignored
//   inc_data  in   new increment value
//   sync      in   phase-align strobe (CLOCK_FRAC_SYNC_EN only)
//   ce_out    out  one-cycle enable pulse per channel (registered carry)
//   clk_out   out  square clock per channel (registered accumulator MSB)
// ---------------------------------------------------------------------------
module clock_frac_gen #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned ACC_BITS    = 32,
    parameter logic [31:0] INC_DEFAULT = 32'h0754B666,
    parameter int unsigned SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk_src,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                inc_we,
    input  logic [SEL_W-1:0]    inc_sel,
    input  logic [ACC_BITS-1:0] inc_data,
`ifdef CLOCK_FRAC_SYNC_EN
    input  logic                sync,
`endif
    output logic [NUM_CH-1:0]   ce_out,
    output logic [NUM_CH-1:0]   clk_out
);

    localparam logic [ACC_BITS-1:0] INC_RST = INC_DEFAULT[ACC_BITS-1:0];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [ACC_BITS-1:0] acc;
        logic [ACC_BITS-1:0] inc;
        logic [ACC_BITS:0]   sum;
        logic                wr_hit;
        logic                ce_q;
        logic                clk_q;

        // An out-of-range inc_sel matches no channel, so the write is dropped.
        always_comb begin
            sum    = {1'b0, acc} + {1'b0, inc};
            wr_hit = inc_we && (inc_sel == SEL_W'(g));
        end

        // The add below reads the pre-write inc, so a retune takes effect
        // from the following cycle. The accumulator keeps its phase.
        always_ff @(posedge clk_src) begin
            if (reset) begin
                acc   <= '0;
                inc   <= INC_RST;
                ce_q  <= 1'b0;
                clk_q <= 1'b0;
            end else begin
                if (wr_hit) begin
                    inc <= inc_data;
                end
                if (!ch_en[g]) begin
                    acc   <= '0;
                    ce_q  <= 1'b0;
                    clk_q <= 1'b0;
                end
`ifdef CLOCK_FRAC_SYNC_EN
                else if (sync) begin
                    // Behaves as an add from acc = 0 but suppresses the pulse.
                    acc   <= inc;
                    ce_q  <= 1'b0;
                    clk_q <= inc[ACC_BITS-1];
                end
`endif
                else begin
                    acc   <= sum[ACC_BITS-1:0];
                    ce_q  <= sum[ACC_BITS];
                    clk_q <= sum[ACC_BITS-1];
                end
            end
        end

        assign ce_out[g]  = ce_q;
        assign clk_out[g] = clk_q;
    end

endmodule

// File: tb/tb_clock_frac_gen.sv
// ---------------------------------------------------------------------------
// tb_clock_frac_gen
//   Directed self-checking bench for clock_frac_gen. Configuration is
//   ACC_BITS=8, NUM_CH=4, and a 3-bit inc_sel so that out-of-range selects
//   can be driven. Inputs change 1 time unit after a rising edge. Outputs
//   are sampled at the same point, so each sample shows the result of the
//   edge just taken.
// ---------------------------------------------------------------------------
module tb_clock_frac_gen;

    logic       clk_src = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] ch_en   = 4'b0000;
    logic       inc_we  = 1'b0;
    logic [2:0] inc_sel = 3'd0;
    logic [7:0] inc_data = 8'h00;
`ifdef CLOCK_FRAC_SYNC_EN
    logic       sync    = 1'b0;
`endif
    logic [3:0] ce_out;
    logic [3:0] clk_out;

    int total = 0;
    int bad   = 0;

    clock_frac_gen #(
        .NUM_CH     (4),
        .ACC_BITS   (8),
        .INC_DEFAULT(32'h0754B666),
        .SEL_W      (3)
    ) dut (
        .clk_src (clk_src),
        .reset   (reset),
        .ch_en   (ch_en),
        .inc_we  (inc_we),
        .inc_sel (inc_sel),
        .inc_data(inc_data),
`ifdef CLOCK_FRAC_SYNC_EN
        .sync    (sync),
`endif
        .ce_out  (ce_out),
        .clk_out (clk_out)
    );

    always #5 clk_src = ~clk_src;

    task automatic tick();
        @(posedge clk_src);
        #1;
    endtask

    task automatic wr_inc(input logic [2:0] sel, input logic [7:0] d);
        inc_we   = 1'b1;
        inc_sel  = sel;
        inc_data = d;
        tick();
        inc_we   = 1'b0;
    endtask

    // Reset state, then the default increment 0x66 seen through its rate.
    task automatic test_reset();
        int cnt [4];
        reset = 1'b1;
        ch_en = 4'b0000;
        repeat (3) tick();
        total++;
        if (ce_out !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ce: got %b want 0000", ce_out);
        end
        total++;
        if (clk_out !== 4'b0000) begin
            bad++;
            $display("FAIL reset_clk: got %b want 0000", clk_out);
        end
        reset = 1'b0;
        ch_en = 4'b1111;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k <= 3) begin
                total++;
                if (ce_out !== ((k == 3) ? 4'b1111 : 4'b0000)) begin
                    bad++;
                    $display("FAIL default_first_ce k=%0d: got %b", k, ce_out);
                end
            end
            for (int i = 0; i < 4; i++) if (ce_out[i]) cnt[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cnt[i] !== 102) begin
                bad++;
                $display("FAIL default_rate ch%0d: got %0d want 102", i, cnt[i]);
            end
        end
        ch_en = 4'b0000;
        tick();
    endtask

    // inc=64: pulse every 4th edge; clk_out high on phases 2 and 3.
    task automatic test_rate_64();
        int cnt;
        logic exp_ce, exp_clk;
        wr_inc(3'd0, 8'd64);
        ch_en = 4'b0001;
        cnt = 0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            exp_ce  = (k % 4 == 0);
            exp_clk = (k % 4 == 2) || (k % 4 == 3);
            total++;
            if (ce_out[0] !== exp_ce || clk_out[0] !== exp_clk) begin
                bad++;
                $display("FAIL rate64 k=%0d: got ce=%b clk=%b want ce=%b clk=%b",
                         k, ce_out[0], clk_out[0], exp_ce, exp_clk);
            end
            if (ce_out[0]) cnt++;
        end
        total++;
        if (cnt !== 16) begin
            bad++;
            $display("FAIL rate64_count: got %0d want 16", cnt);
        end
        total++;
        if (ce_out[3:1] !== 3'b000 || clk_out[3:1] !== 3'b000) begin
            bad++;
            $display("FAIL rate64_idle: got ce=%b clk=%b want 000", ce_out[3:1], clk_out[3:1]);
        end
    endtask

    // inc=96: 300 pulses in 800 edges with spacing 2 or 3, then disable/re-enable.
    task automatic test_rate_96();
        int cnt, last, bad_sp;
        logic [1:0] exp_re [3];
        exp_re[0] = 2'b00;  // acc=96
        exp_re[1] = 2'b01;  // acc=192
        exp_re[2] = 2'b10;  // acc=32, carry
        ch_en = 4'b0000;
        wr_inc(3'd1, 8'd96);
        ch_en = 4'b0010;
        cnt = 0;
        last = 0;
        bad_sp = 0;
        for (int k = 1; k <= 802; k++) begin
            tick();
            if (k <= 800 && ce_out[1]) begin
                cnt++;
                if (last == 0 && k != 3) bad_sp++;
                if (last != 0 && (k - last) != 2 && (k - last) != 3) bad_sp++;
                last = k;
            end
        end
        total++;
        if (cnt !== 300) begin
            bad++;
            $display("FAIL rate96_count: got %0d want 300", cnt);
        end
        total++;
        if (bad_sp !== 0) begin
            bad++;
            $display("FAIL rate96_spacing: got %0d bad gaps want 0", bad_sp);
        end
        total++;
        if (clk_out[1] !== 1'b1) begin
            bad++;
            $display("FAIL rate96_clk_before_dis: got %b want 1", clk_out[1]);
        end
        ch_en = 4'b0000;
        tick();
        total++;
        if ({ce_out[1], clk_out[1]} !== 2'b00) begin
            bad++;
            $display("FAIL disable_outputs: got %b want 00", {ce_out[1], clk_out[1]});
        end
        repeat (2) tick();
        ch_en = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({ce_out[1], clk_out[1]} !== exp_re[k]) begin
                bad++;
                $display("FAIL reenable k=%0d: got %b want %b", k + 1, {ce_out[1], clk_out[1]}, exp_re[k]);
            end
        end
    endtask

    // Phase-continuous retune on ch2, then an out-of-range write.
    task automatic test_retune();
        logic [1:0] exp_seq [10];
        int cnt [4];
        int exp_cnt [4];
        // {ce,clk}; edge 0 carries the 64->128 write, edge 5 carries 128->32.
        exp_seq[0] = 2'b10; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10;
        exp_seq[3] = 2'b01; exp_seq[4] = 2'b10; exp_seq[5] = 2'b01;
        exp_seq[6] = 2'b01; exp_seq[7] = 2'b01; exp_seq[8] = 2'b01;
        exp_seq[9] = 2'b10;
        ch_en = 4'b0000;
        wr_inc(3'd2, 8'd64);
        ch_en = 4'b0100;
        repeat (3) tick();
        total++;
        if ({ce_out[2], clk_out[2]} !== 2'b01) begin
            bad++;
            $display("FAIL retune_pre acc=C0: got %b want 01", {ce_out[2], clk_out[2]});
        end
        for (int k = 0; k < 10; k++) begin
            if (k == 0 || k == 5) begin
                inc_we   = 1'b1;
                inc_sel  = 3'd2;
                inc_data = (k == 0) ? 8'd128 : 8'd32;
            end
            tick();
            inc_we = 1'b0;
            total++;
            if ({ce_out[2], clk_out[2]} !== exp_seq[k]) begin
                bad++;
                $display("FAIL retune edge %0d: got %b want %b", k, {ce_out[2], clk_out[2]}, exp_seq[k]);
            end
        end
        ch_en = 4'b0000;
        tick();
        wr_inc(3'd5, 8'h01);
        wr_inc(3'd2, 8'd128);
        ch_en = 4'b1111;
        exp_cnt[0] = 6; exp_cnt[1] = 9; exp_cnt[2] = 12; exp_cnt[3] = 9;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            for (int i = 0; i < 4; i++) if (ce_out[i]) cnt[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cnt[i] !== exp_cnt[i]) begin
                bad++;
                $display("FAIL sel_oob ch%0d count: got %0d want %0d", i, cnt[i], exp_cnt[i]);
            end
        end
        ch_en = 4'b0000;
        tick();
    endtask

    // Reset in mid-run clears phase and restores the default increment.
    task automatic test_reset_mid();
        logic [1:0] exp_seq [3];
        exp_seq[0] = 2'b00;  // acc=0x66
        exp_seq[1] = 2'b01;  // acc=0xCC
        exp_seq[2] = 2'b10;  // acc=0x32, carry
        ch_en = 4'b0001;
        repeat (6) tick();
        total++;
        if (clk_out[0] !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre: got clk=%b want 1", clk_out[0]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (ce_out !== 4'b0000 || clk_out !== 4'b0000) begin
            bad++;
            $display("FAIL reset_mid_outputs: got ce=%b clk=%b want 0000", ce_out, clk_out);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({ce_out[0], clk_out[0]} !== exp_seq[k]) begin
                bad++;
                $display("FAIL reset_mid_after k=%0d: got %b want %b", k + 1, {ce_out[0], clk_out[0]}, exp_seq[k]);
            end
        end
        ch_en = 4'b0000;
        tick();
    endtask

`ifdef CLOCK_FRAC_SYNC_EN
    task automatic test_sync();
        logic [1:0] exp_ce, exp_clk;
        logic [1:0] exp_seq [3];
        exp_seq[0] = 2'b00;
        exp_seq[1] = 2'b01;
        exp_seq[2] = 2'b10;
        ch_en = 4'b0000;
        wr_inc(3'd0, 8'd64);
        wr_inc(3'd1, 8'd32);
        ch_en = 4'b0001;
        repeat ($urandom_range(1, 7)) tick();
        ch_en = 4'b0011;
        repeat ($urandom_range(1, 13)) tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        total++;
        if (ce_out[1:0] !== 2'b00 || clk_out[1:0] !== 2'b00) begin
            bad++;
            $display("FAIL sync_edge: got ce=%b clk=%b want 00", ce_out[1:0], clk_out[1:0]);
        end
        // After the sync edge acc0 = 64*(k+1), acc1 = 32*(k+1).
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_ce[0]  = ((k + 1) % 4 == 0);
            exp_ce[1]  = ((k + 1) % 8 == 0);
            exp_clk[0] = ((k + 1) % 4 >= 2);
            exp_clk[1] = ((k + 1) % 8 >= 4);
            total++;
            if (ce_out[1:0] !== exp_ce || clk_out[1:0] !== exp_clk) begin
                bad++;
                $display("FAIL sync_after k=%0d: got ce=%b clk=%b want ce=%b clk=%b",
                         k, ce_out[1:0], clk_out[1:0], exp_ce, exp_clk);
            end
        end
        ch_en = 4'b0001;
        reset = 1'b1;
        sync  = 1'b1;
        tick();
        reset = 1'b0;
        sync  = 1'b0;
        total++;
        if (ce_out !== 4'b0000 || clk_out !== 4'b0000) begin
            bad++;
            $display("FAIL sync_reset_edge: got ce=%b clk=%b want 0000", ce_out, clk_out);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({ce_out[0], clk_out[0]} !== exp_seq[k]) begin
                bad++;
                $display("FAIL sync_reset_after k=%0d: got %b want %b", k + 1, {ce_out[0], clk_out[0]}, exp_seq[k]);
            end
        end
        ch_en = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_rate_64();
        test_rate_96();
        test_retune();
        test_reset_mid();
`ifdef CLOCK_FRAC_SYNC_EN
        test_sync();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
